core_int_arbiter: RTL
=====================

Name: core_int_arbiter

Overview:
- Parametrised successor to the fixed three-source interrupt logic: NINT sources, each with its own enable, priority and trigger mode (edge or level).
- Latches edge-triggered pending bits and arbitrates by priority against a threshold.
- Presents a registered, stable request/cause/vector to the execute stage and handles the ack handshake.
- Sits between the CSR file (enables, priorities, mtvec) and the pipeline trap logic.

Parameters:
- XLEN, 64, data/address width; XL = XLEN-1.
- NINT, 16, number of interrupt sources; source i reports cause code i. Range 1..64.
- PRIO_W, 3, priority field width per source.
- CAUSE_W, 7, width of int_cause.
- EDGE_MASK, 16'h0000, bit i set = source i is edge-triggered, clear = level.

Ports:
- g_clk  in  1  global clock
- g_resetn  in  1  synchronous active-low reset
- int_src  in  NINT  raw interrupt lines
- int_en  in  NINT  per-source enable (mie)
- int_prio  in  NINT*PRIO_W  priorities, source i at [i*PRIO_W +: PRIO_W]
- int_thresh  in  PRIO_W  priority threshold
- int_clr  in  NINT  software clear of edge-pending bits (one-cycle pulses)
- mstatus_mie  in  1  global enable
- mtvec_base  in  XLEN  trap vector base (low 2 bits zero)
- mtvec_mode  in  2  bit0 set = vectored
- int_pending  out  NINT  pending view for mip
- int_request  out  1  interrupt to be taken
- int_cause  out  CAUSE_W  cause of presented interrupt
- int_tvec  out  XLEN  trap target
- int_ack  in  1  trap taken for the presented cause

Behaviour:
- Reset: pending regs 0, FSM IDLE, int_request 0, int_cause 0, int_tvec 0, edge history 0.
- Edge sources: pend[i] sets on a 0->1 transition of the (optionally synchronised) input. Clears on int_clr[i], or on ack while int_cause == i. If set and clear occur in the same cycle, set wins.
- Level sources: pend[i] follows the input combinationally after sampling; int_clr and ack have no effect.
- int_pending = pend, ignoring enables.
- Eligible[i] = pend[i] && int_en[i] && prio[i] > int_thresh. Priority 0 is therefore never taken.
- Winner = highest priority among eligible sources; ties go to the lowest index.
- Vector: tvec = mtvec_base + (mode_vector ? cause*4 : 0). This is a full XLEN adder, not an OR.
- FSM:
  - IDLE: if a winner exists && mstatus_mie, register cause/tvec, int_request = 1 next cycle, go to REQ.
  - REQ: int_cause and int_tvec are held stable. A higher-priority arrival does not preempt.
    - int_ack: clear the edge pend for the cause, int_request = 0, go to HOLD.
    - Otherwise, if the presented source is no longer eligible or mstatus_mie = 0: withdraw, int_request = 0, go to IDLE.
  - HOLD: exactly one cycle with int_request = 0 so that the mstatus_mie clear lands; then IDLE.
- Latency: source edge -> int_request is 2 cycles (pend reg + FSM), or 4 cycles with the synchroniser.
- int_ack outside REQ is ignored. int_cause and int_tvec hold their last values when idle.

Optional Feature:
- CORE_INT_SYNC_EN defined: each int_src bit passes through a 2-flop synchroniser (reset 0) before edge detect and level use. This adds 2 cycles of latency.
- Not defined: int_src is sampled directly. Edge detection still uses a 1-flop history.

Decomposition:
- core_common.svh / package: CAUSE_W, the FSM state enum (IDLE/REQ/HOLD), and TRAP_INT_* cause constants.
- Sub-module core_int_prio_tree: combinational priority/index select over NINT (returns valid, index, prio). Instantiated once.

Test Plan:
- Level source 3, prio 2, thresh 0, mie = 1 -> int_request rises 2 cycles later, cause = 3; direct mode gives tvec = base 0x8000_0000.
- Vectored mode, edge source 11 -> tvec = 0x8000_0000 + 44. Ack -> pend[11] = 0, request low in HOLD and the following IDLE cycle.
- Sources 5 and 9 both prio 4 -> cause 5. Then set prio[9] = 6 -> next arbitration (after ack) gives cause 9.
- prio[7] = 2 with thresh = 2 -> no request. Lower thresh to 1 -> request with cause 7.
- Level source drops while in REQ without ack -> int_request withdrawn the next cycle, FSM returns to IDLE.
- New edge on source 4 in the same cycle as the ack of cause 4 -> pend[4] stays 1 and the request re-raises after HOLD. Reset mid-REQ -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/core_int_arbiter_pkg.sv
// Shared types and constants for the interrupt arbiter: FSM state encoding,
// default cause width, standard machine interrupt cause codes.
package core_int_arbiter_pkg;

    localparam int unsigned DEF_CAUSE_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } int_state_e;

    localparam logic [DEF_CAUSE_W-1:0] TRAP_INT_MSI = 7'd3;
    localparam logic [DEF_CAUSE_W-1:0] TRAP_INT_MTI = 7'd7;
    localparam logic [DEF_CAUSE_W-1:0] TRAP_INT_MEI = 7'd11;

    // Index width that stays legal for a single source.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/core_int_prio_tree.sv
// Combinational winner select: highest priority among eligible sources,
// ties resolved towards the lowest index.
module core_int_prio_tree
    import core_int_arbiter_pkg::*;
#(
    parameter int unsigned NINT   = 16,
    parameter int unsigned PRIO_W = 3,
    parameter int unsigned IDX_W  = idx_w(NINT)
) (
    input  logic [NINT-1:0]        elig,
    input  logic [NINT*PRIO_W-1:0] prio,
    output logic                   valid,
    output logic [IDX_W-1:0]       index,
    output logic [PRIO_W-1:0]      best_prio
);

    always_comb begin
        valid     = 1'b0;
        index     = '0;
        best_prio = '0;
        // Strict compare keeps the earlier (lower) index on a tie.
        for (int i = 0; i < int'(NINT); i++) begin
            if (elig[i] && (!valid || (prio[i*PRIO_W +: PRIO_W] > best_prio))) begin
                valid     = 1'b1;
                index     = IDX_W'(i);
                best_prio = prio[i*PRIO_W +: PRIO_W];
            end
        end
    end

endmodule

// File: rtl/core_int_arbiter.sv
// NINT-source interrupt arbiter: pending latch, priority/threshold select,
// registered request/cause/vector with ack handshake. Option: CORE_INT_SYNC_EN.
module core_int_arbiter
    import core_int_arbiter_pkg::*;
#(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned NINT    = 16,
    parameter int unsigned PRIO_W  = 3,
    parameter int unsigned CAUSE_W = DEF_CAUSE_W,
    parameter logic [NINT-1:0] EDGE_MASK = '0
) (
    input  logic                   g_clk,
    input  logic                   g_resetn,
    input  logic [NINT-1:0]        int_src,
    input  logic [NINT-1:0]        int_en,
    input  logic [NINT*PRIO_W-1:0] int_prio,
    input  logic [PRIO_W-1:0]      int_thresh,
    input  logic [NINT-1:0]        int_clr,
    input  logic                   mstatus_mie,
    input  logic [XLEN-1:0]        mtvec_base,
    input  logic [1:0]             mtvec_mode,
    output logic [NINT-1:0]        int_pending,
    output logic                   int_request,
    output logic [CAUSE_W-1:0]     int_cause,
    output logic [XLEN-1:0]        int_tvec,
    input  logic                   int_ack
);

    localparam int unsigned IDX_W = idx_w(NINT);

    logic [NINT-1:0]   src_s;
    logic [NINT-1:0]   src_prev;
    logic [NINT-1:0]   pend;
    logic [NINT-1:0]   pend_next;
    logic [NINT-1:0]   rise;
    logic [NINT-1:0]   ack_clr;
    logic [NINT-1:0]   elig;
    int_state_e        state;
    logic [IDX_W-1:0]  cause_idx;
    logic              win_valid;
    logic [IDX_W-1:0]  win_idx;
    logic [PRIO_W-1:0] win_prio_unused;
    logic [PRIO_W-1:0] cur_prio;
    logic              cur_elig;
    logic [XLEN-1:0]   tvec_calc;
    logic              mode_unused;

    assign mode_unused = mtvec_mode[1];

    // Input stage: optional two-flop synchroniser ahead of edge detect.
`ifdef CORE_INT_SYNC_EN
    logic [NINT-1:0] src_p0;
    logic [NINT-1:0] src_p1;

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            src_p0 <= '0;
            src_p1 <= '0;
        end else begin
            src_p0 <= int_src;
            src_p1 <= src_p0;
        end
    end

    assign src_s = src_p1;
`else
    assign src_s = int_src;
`endif

    // Pending stage: edge bits latch with set-over-clear, level bits track the input.
    assign rise      = src_s & ~src_prev;
    assign ack_clr   = (state == ST_REQ && int_ack) ? (NINT'(1) << cause_idx) : '0;
    assign pend_next = (EDGE_MASK & (rise | (pend & ~(int_clr | ack_clr))))
                     | (~EDGE_MASK & src_s);

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            src_prev <= '0;
            pend     <= '0;
        end else begin
            src_prev <= src_s;
            pend     <= pend_next;
        end
    end

    assign int_pending = pend;

    always_comb begin
        elig = '0;
        for (int i = 0; i < int'(NINT); i++) begin
            elig[i] = pend[i] && int_en[i] && (int_prio[i*PRIO_W +: PRIO_W] > int_thresh);
        end
    end

    core_int_prio_tree #(
        .NINT   (NINT),
        .PRIO_W (PRIO_W),
        .IDX_W  (IDX_W)
    ) u_prio_tree (
        .elig      (elig),
        .prio      (int_prio),
        .valid     (win_valid),
        .index     (win_idx),
        .best_prio (win_prio_unused)
    );

    assign cur_prio  = int_prio[int'(cause_idx)*PRIO_W +: PRIO_W];
    assign cur_elig  = pend[cause_idx] && int_en[cause_idx] && (cur_prio > int_thresh);
    assign tvec_calc = mtvec_base + (mtvec_mode[0] ? (XLEN'(win_idx) << 2) : '0);

    // Request stage: present, hold stable until ack or withdrawal, then one quiet cycle.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state       <= ST_IDLE;
            cause_idx   <= '0;
            int_request <= 1'b0;
            int_cause   <= '0;
            int_tvec    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_valid && mstatus_mie) begin
                        cause_idx   <= win_idx;
                        int_cause   <= CAUSE_W'(win_idx);
                        int_tvec    <= tvec_calc;
                        int_request <= 1'b1;
                        state       <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (int_ack) begin
                        int_request <= 1'b0;
                        state       <= ST_HOLD;
                    end else if (!cur_elig || !mstatus_mie) begin
                        int_request <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    int_request <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: begin
                    int_request <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
